mc_control: RTL and testbench

MC_CONTROL -- requirements
Module: mc_control

---
 rtl/mc_control_if.sv | 48 ++++
 rtl/mc_control.sv | 240 ++++++++++++++++++++++++
 tb/tb_mc_control.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mc_control_if.sv
// Control bundle between the multi-cycle controller and its datapath.
// The controller side (master) reads the instruction fields and ALU flags
// and drives every strobe, mux select and status output.
interface mc_control_if;
  logic [5:0] Op;
  logic [5:0] Funct;
  logic       ALU_zero;
  logic       ALU_overflow;
  logic [7:0] StateOut;
  logic       PCWrite;
  logic       PCWriteCond;
  logic       PCWriteCondN;
  logic       PC_load;
  logic       wr;
  logic       IorD;
  logic       IRWrite;
  logic       MDR_load;
  logic       A_load;
  logic       B_load;
  logic       ALUOut_load;
  logic       RegWrite;
  logic       EPC_load;
  logic       DP_reset;
  logic [2:0] ALU_sel;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] MemtoReg;
  logic       RegDst;
  logic [1:0] PCSource;
  logic [1:0] Cause;
  logic       halted;

  modport master (
    input  Op, Funct, ALU_zero, ALU_overflow,
    output StateOut, PCWrite, PCWriteCond, PCWriteCondN, PC_load, wr, IorD,
           IRWrite, MDR_load, A_load, B_load, ALUOut_load, RegWrite, EPC_load,
           DP_reset, ALU_sel, ALUSrcA, ALUSrcB, MemtoReg, RegDst, PCSource,
           Cause, halted
  );

  modport slave (
    output Op, Funct, ALU_zero, ALU_overflow,
    input  StateOut, PCWrite, PCWriteCond, PCWriteCondN, PC_load, wr, IorD,
           IRWrite, MDR_load, A_load, B_load, ALUOut_load, RegWrite, EPC_load,
           DP_reset, ALU_sel, ALUSrcA, ALUSrcB, MemtoReg, RegDst, PCSource,
           Cause, halted
  );
endinterface

// File: rtl/mc_control.sv
// mc_control: Moore controller for a multi-cycle MIPS-style datapath.
// Memory accesses (fetch, load, store) last MEM_WAIT cycles each, timed by a
// down-counter. Strobes decode from the state register; StateOut and Cause
// are registered.
module mc_control #(
  parameter int unsigned MEM_WAIT   = 2,
  parameter bit          EXC_ENABLE = 1'b1
) (
  input  logic         Clk,
  input  logic         Reset_signal,
  mc_control_if.master bus
);

  typedef enum logic [3:0] {
    S_RESET      = 4'd0,
    S_FETCH      = 4'd1,
    S_FETCH_WAIT = 4'd2,
    S_DECODE     = 4'd3,
    S_EXEC_R     = 4'd4,
    S_WB_R       = 4'd5,
    S_BRANCH     = 4'd6,
    S_MEM_ADDR   = 4'd7,
    S_LW_WAIT    = 4'd8,
    S_LW_WB      = 4'd9,
    S_SW_WAIT    = 4'd10,
    S_LUI_WB     = 4'd11,
    S_JUMP       = 4'd12,
    S_EXC        = 4'd13,
    S_HALT       = 4'd14
  } state_t;

  localparam logic [3:0] WAIT_INIT = 4'(MEM_WAIT - 1);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_NOP   = 6'h00;
  localparam logic [5:0] FN_BREAK = 6'h0D;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_XOR   = 6'h26;

  state_t     state_r, next_state_s, decoded_s, dispatch_s;
  logic [3:0] cnt_r;
  logic [1:0] cause_r, cause_next_s;
  logic       cnt_zero_s, is_arith_s, ovf_trap_s, illegal_s;

  assign cnt_zero_s = (cnt_r == 4'd0);
  assign is_arith_s = (bus.Funct == FN_ADD) || (bus.Funct == FN_SUB);
  // Only add/sub can trap; and/xor ignore the overflow flag.
  assign ovf_trap_s = EXC_ENABLE && is_arith_s && bus.ALU_overflow;

  // Instruction decode: which state follows DECODE for the current IR.
  always_comb begin
    decoded_s = S_FETCH;
    illegal_s = 1'b0;
    case (bus.Op)
      OP_RTYPE: begin
        case (bus.Funct)
          FN_ADD, FN_SUB, FN_AND, FN_XOR: decoded_s = S_EXEC_R;
          FN_NOP:                         decoded_s = S_FETCH;
          FN_BREAK:                       decoded_s = S_HALT;
          default:                        illegal_s = 1'b1;
        endcase
      end
      OP_BEQ, OP_BNE: decoded_s = S_BRANCH;
      OP_LW, OP_SW:   decoded_s = S_MEM_ADDR;
      OP_LUI:         decoded_s = S_LUI_WB;
      OP_J:           decoded_s = S_JUMP;
      default:        illegal_s = 1'b1;
    endcase
    // With exceptions disabled an illegal instruction behaves as a nop.
    dispatch_s = (illegal_s && EXC_ENABLE) ? S_EXC : decoded_s;
  end

  // Next-state selection and the exception cause captured on entry to EXC.
  always_comb begin
    next_state_s = state_r;
    cause_next_s = cause_r;
    case (state_r)
      S_RESET:      next_state_s = S_FETCH;
      S_FETCH:      next_state_s = S_FETCH_WAIT;
      S_FETCH_WAIT: next_state_s = cnt_zero_s ? S_DECODE : S_FETCH_WAIT;
      S_DECODE: begin
        next_state_s = dispatch_s;
        cause_next_s = (dispatch_s == S_EXC) ? 2'b10 : cause_r;
      end
      S_EXEC_R: begin
        next_state_s = ovf_trap_s ? S_EXC : S_WB_R;
        cause_next_s = ovf_trap_s ? 2'b01 : cause_r;
      end
      S_MEM_ADDR:   next_state_s = (bus.Op == OP_SW) ? S_SW_WAIT : S_LW_WAIT;
      S_LW_WAIT:    next_state_s = cnt_zero_s ? S_LW_WB : S_LW_WAIT;
      S_SW_WAIT:    next_state_s = cnt_zero_s ? S_FETCH : S_SW_WAIT;
      S_WB_R, S_BRANCH, S_LW_WB, S_LUI_WB, S_JUMP, S_EXC:
                    next_state_s = S_FETCH;
      S_HALT:       next_state_s = S_HALT;
      default:      next_state_s = S_RESET;
    endcase
  end

  // State, cause and delayed state-code registers.
  always_ff @(posedge Clk or posedge Reset_signal) begin
    if (Reset_signal) begin
      state_r      <= S_RESET;
      cause_r      <= 2'b00;
      bus.StateOut <= 8'd0;
    end else begin
      state_r      <= next_state_s;
      cause_r      <= cause_next_s;
      bus.StateOut <= {4'd0, state_r};
    end
  end

  // Memory wait counter: loaded when an access starts, counts down to 0.
  always_ff @(posedge Clk or posedge Reset_signal) begin
    if (Reset_signal) begin
      cnt_r <= 4'd0;
    end else begin
      case (state_r)
        S_FETCH, S_MEM_ADDR:               cnt_r <= WAIT_INIT;
        S_FETCH_WAIT, S_LW_WAIT, S_SW_WAIT: cnt_r <= cnt_zero_s ? 4'd0 : (cnt_r - 4'd1);
        default:                           cnt_r <= cnt_r;
      endcase
    end
  end

  // Moore output decode; everything not driven by the current state stays 0.
  always_comb begin
    bus.PCWrite      = 1'b0;
    bus.PCWriteCond  = 1'b0;
    bus.PCWriteCondN = 1'b0;
    bus.wr           = 1'b0;
    bus.IorD         = 1'b0;
    bus.IRWrite      = 1'b0;
    bus.MDR_load     = 1'b0;
    bus.A_load       = 1'b0;
    bus.B_load       = 1'b0;
    bus.ALUOut_load  = 1'b0;
    bus.RegWrite     = 1'b0;
    bus.EPC_load     = 1'b0;
    bus.DP_reset     = 1'b0;
    bus.ALU_sel      = 3'b000;
    bus.ALUSrcA      = 1'b0;
    bus.ALUSrcB      = 2'b00;
    bus.MemtoReg     = 2'b00;
    bus.RegDst       = 1'b0;
    bus.PCSource     = 2'b00;
    bus.halted       = 1'b0;
    case (state_r)
      S_RESET: bus.DP_reset = 1'b1;
      S_FETCH: begin
        bus.IorD = 1'b0;
        bus.wr   = 1'b0;
      end
      S_FETCH_WAIT: begin
        // Instruction word arrives on the last wait cycle; PC += 4 alongside.
        bus.IRWrite  = cnt_zero_s;
        bus.MDR_load = cnt_zero_s;
        bus.PCWrite  = cnt_zero_s;
        bus.ALUSrcB  = cnt_zero_s ? 2'b01 : 2'b00;
        bus.ALU_sel  = cnt_zero_s ? 3'b001 : 3'b000;
      end
      S_DECODE: begin
        // Register read plus speculative branch-target computation.
        bus.A_load      = 1'b1;
        bus.B_load      = 1'b1;
        bus.ALUOut_load = 1'b1;
        bus.ALUSrcB     = 2'b11;
        bus.ALU_sel     = 3'b001;
      end
      S_EXEC_R: begin
        bus.ALUSrcA     = 1'b1;
        bus.ALUOut_load = 1'b1;
        case (bus.Funct)
          FN_ADD:  bus.ALU_sel = 3'b001;
          FN_SUB:  bus.ALU_sel = 3'b010;
          FN_AND:  bus.ALU_sel = 3'b011;
          FN_XOR:  bus.ALU_sel = 3'b100;
          default: bus.ALU_sel = 3'b000;
        endcase
      end
      S_WB_R: begin
        bus.RegWrite = 1'b1;
        bus.RegDst   = 1'b1;
      end
      S_BRANCH: begin
        bus.ALUSrcA      = 1'b1;
        bus.ALU_sel      = 3'b010;
        bus.PCSource     = 2'b01;
        bus.PCWriteCond  = (bus.Op == OP_BEQ);
        bus.PCWriteCondN = (bus.Op == OP_BNE);
      end
      S_MEM_ADDR: begin
        bus.ALUSrcA     = 1'b1;
        bus.ALUSrcB     = 2'b10;
        bus.ALU_sel     = 3'b001;
        bus.ALUOut_load = 1'b1;
      end
      S_LW_WAIT: begin
        bus.IorD     = 1'b1;
        bus.MDR_load = cnt_zero_s;
      end
      S_SW_WAIT: begin
        bus.IorD = 1'b1;
        bus.wr   = 1'b1;
      end
      S_LW_WB: begin
        bus.RegWrite = 1'b1;
        bus.MemtoReg = 2'b01;
      end
      S_LUI_WB: begin
        bus.RegWrite = 1'b1;
        bus.MemtoReg = 2'b10;
      end
      S_JUMP: begin
        bus.PCWrite  = 1'b1;
        bus.PCSource = 2'b10;
      end
      S_EXC: begin
        bus.EPC_load = 1'b1;
        bus.PCWrite  = 1'b1;
        bus.PCSource = 2'b11;
      end
      S_HALT:  bus.halted = 1'b1;
      // Unused encoding: clear the datapath while recovering through RESET.
      default: bus.DP_reset = 1'b1;
    endcase
    bus.PC_load = bus.PCWrite | (bus.PCWriteCond & bus.ALU_zero) |
                  (bus.PCWriteCondN & ~bus.ALU_zero);
    bus.Cause   = cause_r;
  end

endmodule

// File: tb/tb_mc_control.sv
// Self-checking bench for mc_control. Three instances cover
// MEM_WAIT=2/EXC on, MEM_WAIT=3/EXC on and MEM_WAIT=2/EXC off; only the
// selected one is out of reset. A reference model expands each instruction
// into its expected per-cycle output vectors, checked one per clock.
module tb_mc_control;

  typedef struct packed {
    logic [7:0] so;
    logic       pcw, pcwc, pcwcn, pcl, wr, iord, irw, mdr;
    logic       al, bl, aol, rw, epc, dpr;
    logic [2:0] alu;
    logic       srca;
    logic [1:0] srcb, m2r;
    logic       rdst;
    logic [1:0] pcs, cause;
    logic       halted;
  } obs_t;

  logic       Clk;
  logic [2:0] rst_v;
  logic [5:0] op_v, fn_v;
  logic       zero_v, ovf_v;

  int   sel, mw;
  bit   exc_en;
  int   n_chk, n_pass, n_fail;
  obs_t eq[$];
  int   m_prev;
  logic [1:0] m_cause;
  string cur_tag;
  bit   pend;
  logic [5:0] p_op, p_fn;
  logic p_zr, p_ov;
  obs_t obs, obs_a, obs_b, obs_c;

  mc_control_if ifa ();
  mc_control_if ifb ();
  mc_control_if ifc ();

  assign ifa.Op = op_v;  assign ifa.Funct = fn_v;  assign ifa.ALU_zero = zero_v;  assign ifa.ALU_overflow = ovf_v;
  assign ifb.Op = op_v;  assign ifb.Funct = fn_v;  assign ifb.ALU_zero = zero_v;  assign ifb.ALU_overflow = ovf_v;
  assign ifc.Op = op_v;  assign ifc.Funct = fn_v;  assign ifc.ALU_zero = zero_v;  assign ifc.ALU_overflow = ovf_v;

  mc_control #(.MEM_WAIT(2), .EXC_ENABLE(1'b1)) u_a (.Clk(Clk), .Reset_signal(rst_v[0]), .bus(ifa));
  mc_control #(.MEM_WAIT(3), .EXC_ENABLE(1'b1)) u_b (.Clk(Clk), .Reset_signal(rst_v[1]), .bus(ifb));
  mc_control #(.MEM_WAIT(2), .EXC_ENABLE(1'b0)) u_c (.Clk(Clk), .Reset_signal(rst_v[2]), .bus(ifc));

  assign obs_a = {ifa.StateOut, ifa.PCWrite, ifa.PCWriteCond, ifa.PCWriteCondN, ifa.PC_load, ifa.wr, ifa.IorD,
                  ifa.IRWrite, ifa.MDR_load, ifa.A_load, ifa.B_load, ifa.ALUOut_load, ifa.RegWrite, ifa.EPC_load,
                  ifa.DP_reset, ifa.ALU_sel, ifa.ALUSrcA, ifa.ALUSrcB, ifa.MemtoReg, ifa.RegDst, ifa.PCSource,
                  ifa.Cause, ifa.halted};
  assign obs_b = {ifb.StateOut, ifb.PCWrite, ifb.PCWriteCond, ifb.PCWriteCondN, ifb.PC_load, ifb.wr, ifb.IorD,
                  ifb.IRWrite, ifb.MDR_load, ifb.A_load, ifb.B_load, ifb.ALUOut_load, ifb.RegWrite, ifb.EPC_load,
                  ifb.DP_reset, ifb.ALU_sel, ifb.ALUSrcA, ifb.ALUSrcB, ifb.MemtoReg, ifb.RegDst, ifb.PCSource,
                  ifb.Cause, ifb.halted};
  assign obs_c = {ifc.StateOut, ifc.PCWrite, ifc.PCWriteCond, ifc.PCWriteCondN, ifc.PC_load, ifc.wr, ifc.IorD,
                  ifc.IRWrite, ifc.MDR_load, ifc.A_load, ifc.B_load, ifc.ALUOut_load, ifc.RegWrite, ifc.EPC_load,
                  ifc.DP_reset, ifc.ALU_sel, ifc.ALUSrcA, ifc.ALUSrcB, ifc.MemtoReg, ifc.RegDst, ifc.PCSource,
                  ifc.Cause, ifc.halted};

  // Route the selected instance to the checker.
  always_comb begin
    case (sel)
      1:       obs = obs_b;
      2:       obs = obs_c;
      default: obs = obs_a;
    endcase
  end

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  function automatic obs_t blank();
    obs_t o;
    o = '0;
    return o;
  endfunction

  function automatic obs_t reset_obs();
    obs_t o;
    o = '0;
    o.dpr = 1'b1;
    return o;
  endfunction

  task automatic check_obs(input string tag, input obs_t e);
    n_chk++;
    assert (obs === e) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s #%0d: observed %h expected %h", tag, n_chk, obs, e);
    end
  endtask

  // Queue one expected cycle; StateOut lags the state by one cycle.
  task automatic push(input int st, input obs_t o);
    o.so    = 8'(m_prev);
    o.cause = m_cause;
    eq.push_back(o);
    m_prev  = st;
  endtask

  task automatic push_exc(input logic [1:0] c);
    obs_t o;
    m_cause = c;
    o = blank(); o.epc = 1'b1; o.pcw = 1'b1; o.pcl = 1'b1; o.pcs = 2'b11;
    push(13, o);
  endtask

  // Expand one instruction into its expected cycles, FETCH onwards.
  task automatic model_instr(input logic [5:0] op, input logic [5:0] fn, input logic zr, input logic ov);
    obs_t o;
    bit   r_alu, arith, invalid;
    o = blank();
    push(1, o);
    for (int i = 0; i < mw; i++) begin
      o = blank();
      if (i == mw - 1) begin
        o.irw = 1'b1; o.mdr = 1'b1; o.pcw = 1'b1; o.pcl = 1'b1; o.srcb = 2'b01; o.alu = 3'b001;
      end
      push(2, o);
    end
    o = blank(); o.al = 1'b1; o.bl = 1'b1; o.aol = 1'b1; o.srcb = 2'b11; o.alu = 3'b001;
    push(3, o);
    arith   = (fn == 6'h20) || (fn == 6'h22);
    r_alu   = (op == 6'h00) && (arith || fn == 6'h24 || fn == 6'h26);
    invalid = 1'b0;
    if (r_alu) begin
      o = blank(); o.srca = 1'b1; o.aol = 1'b1;
      o.alu = (fn == 6'h20) ? 3'b001 : (fn == 6'h22) ? 3'b010 : (fn == 6'h24) ? 3'b011 : 3'b100;
      push(4, o);
      if (exc_en && ov && arith) push_exc(2'b01);
      else begin
        o = blank(); o.rw = 1'b1; o.rdst = 1'b1;
        push(5, o);
      end
    end else if (op == 6'h00 && fn == 6'h0D) begin
      o = blank(); o.halted = 1'b1;
      push(14, o);
    end else if (op == 6'h04 || op == 6'h05) begin
      o = blank(); o.srca = 1'b1; o.alu = 3'b010; o.pcs = 2'b01;
      o.pcwc  = (op == 6'h04);
      o.pcwcn = (op == 6'h05);
      o.pcl   = (op == 6'h04) ? zr : ~zr;
      push(6, o);
    end else if (op == 6'h23 || op == 6'h2B) begin
      o = blank(); o.srca = 1'b1; o.srcb = 2'b10; o.alu = 3'b001; o.aol = 1'b1;
      push(7, o);
      for (int i = 0; i < mw; i++) begin
        o = blank(); o.iord = 1'b1;
        if (op == 6'h2B) o.wr = 1'b1;
        else o.mdr = (i == mw - 1);
        push((op == 6'h2B) ? 10 : 8, o);
      end
      if (op == 6'h23) begin
        o = blank(); o.rw = 1'b1; o.m2r = 2'b01;
        push(9, o);
      end
    end else if (op == 6'h0F) begin
      o = blank(); o.rw = 1'b1; o.m2r = 2'b10;
      push(11, o);
    end else if (op == 6'h02) begin
      o = blank(); o.pcw = 1'b1; o.pcl = 1'b1; o.pcs = 2'b10;
      push(12, o);
    end else if (!(op == 6'h00 && fn == 6'h00)) begin
      invalid = 1'b1;
    end
    if (invalid && exc_en) push_exc(2'b10);
  endtask

  // Step n cycles, checking each against the head of the expectation queue.
  task automatic drain(input int n);
    for (int k = 0; k < n; k++) begin
      obs_t e;
      @(negedge Clk);
      if (pend) begin
        op_v = p_op; fn_v = p_fn; zero_v = p_zr; ovf_v = p_ov;
        pend = 1'b0;
      end
      #1;
      e = eq.pop_front();
      check_obs(cur_tag, e);
    end
  endtask

  task automatic begin_instr(input string tag, input logic [5:0] op, input logic [5:0] fn,
                             input logic zr, input logic ov);
    cur_tag = tag;
    p_op = op; p_fn = fn; p_zr = zr; p_ov = ov;
    pend = 1'b1;
    model_instr(op, fn, zr, ov);
  endtask

  task automatic run_instr(input string tag, input logic [5:0] op, input logic [5:0] fn,
                           input logic zr, input logic ov);
    begin_instr(tag, op, fn, zr, ov);
    drain(eq.size());
  endtask

  // Reset between clock edges and check it takes effect without an edge.
  task automatic abort_with_reset(input string tag);
    #2;
    rst_v[sel] = 1'b1;
    #1;
    check_obs(tag, reset_obs());
    eq.delete();
    pend = 1'b0;
    @(negedge Clk);
    #1;
    rst_v[sel] = 1'b0;
    m_prev  = 0;
    m_cause = 2'b00;
  endtask

  task automatic start_dut(input int s, input int w, input bit e);
    rst_v  = 3'b111;
    sel    = s;
    mw     = w;
    exc_en = e;
    pend   = 1'b0;
    eq.delete();
    @(negedge Clk);
    #1;
    check_obs("reset_held", reset_obs());
    rst_v[s] = 1'b0;
    m_prev   = 0;
    m_cause  = 2'b00;
    #1;
    check_obs("reset_released", reset_obs());
  endtask

  task automatic run_random(input int n);
    for (int i = 0; i < n; i++) begin
      logic [5:0] op, fn;
      logic       zr, ov;
      int unsigned kind;
      kind = $urandom_range(0, 12);
      zr   = 1'($urandom_range(0, 1));
      ov   = 1'($urandom_range(0, 1));
      op   = 6'h00;
      fn   = 6'($urandom_range(0, 63));
      case (kind)
        0:  fn = 6'h20;
        1:  fn = 6'h22;
        2:  fn = 6'h24;
        3:  fn = 6'h26;
        4:  fn = 6'h00;
        5:  op = 6'h04;
        6:  op = 6'h05;
        7:  op = 6'h23;
        8:  op = 6'h2B;
        9:  op = 6'h0F;
        10: op = 6'h02;
        11: begin
          do op = 6'($urandom_range(1, 63));
          while (op == 6'h02 || op == 6'h04 || op == 6'h05 || op == 6'h0F || op == 6'h23 || op == 6'h2B);
        end
        default: begin
          do fn = 6'($urandom_range(0, 63));
          while (fn == 6'h00 || fn == 6'h0D || fn == 6'h20 || fn == 6'h22 || fn == 6'h24 || fn == 6'h26);
        end
      endcase
      run_instr("random", op, fn, zr, ov);
    end
  endtask

  initial begin
    obs_t o;
    n_chk = 0; n_pass = 0; n_fail = 0;
    rst_v = 3'b111;
    op_v = 6'h00; fn_v = 6'h00; zero_v = 1'b0; ovf_v = 1'b0;
    sel = 0; mw = 2; exc_en = 1'b1; pend = 1'b0;
    m_prev = 0; m_cause = 2'b00;

    // MEM_WAIT=2, exceptions enabled.
    start_dut(0, 2, 1'b1);
    run_instr("add", 6'h00, 6'h20, 1'b0, 1'b0);
    run_instr("beq_taken", 6'h04, 6'h11, 1'b1, 1'b0);
    run_instr("bne_not_taken", 6'h05, 6'h11, 1'b1, 1'b0);
    run_instr("sub_ovf", 6'h00, 6'h22, 1'b0, 1'b1);
    run_instr("bad_op", 6'h3F, 6'h00, 1'b0, 1'b0);
    begin_instr("lw_abort", 6'h23, 6'h00, 1'b0, 1'b0);
    drain(2);
    abort_with_reset("rst_mid_fetch");
    run_random(40);
    run_instr("break", 6'h00, 6'h0D, 1'b0, 1'b0);
    cur_tag = "halt_hold";
    for (int i = 0; i < 20; i++) begin
      o = blank(); o.halted = 1'b1;
      push(14, o);
    end
    drain(20);
    abort_with_reset("halt_rst");
    run_instr("after_halt", 6'h00, 6'h24, 1'b0, 1'b1);

    // MEM_WAIT=3, exceptions enabled.
    start_dut(1, 3, 1'b1);
    run_instr("lw", 6'h23, 6'h00, 1'b0, 1'b0);
    run_instr("sw", 6'h2B, 6'h00, 1'b1, 1'b0);
    begin_instr("sw_abort", 6'h2B, 6'h00, 1'b0, 1'b0);
    drain(7);
    abort_with_reset("rst_mid_store");
    run_instr("lui", 6'h0F, 6'h00, 1'b0, 1'b0);
    run_random(30);

    // MEM_WAIT=2, exceptions disabled.
    start_dut(2, 2, 1'b0);
    run_instr("sub_ovf_noexc", 6'h00, 6'h22, 1'b0, 1'b1);
    run_instr("bad_op_noexc", 6'h3F, 6'h00, 1'b0, 1'b0);
    run_instr("bad_fn_noexc", 6'h00, 6'h3F, 1'b0, 1'b0);
    run_random(30);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
